// File: rtl/instruction_loader.sv
// Instruction loader: accepts a stream of 32-bit words and writes them
// big-endian, one byte per cycle, into a byte-wide instruction memory.
// A separate read port returns a registered 32-bit fetch word every cycle.
module instruction_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [6:0]        load_len,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        remaining;
  logic [1:0]        byte_idx;
  logic [31:0]       word_reg;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_byte_addr;
  logic [7:0]        wr_byte;

  logic [ADDR_W-1:0] rd_addr1, rd_addr2, rd_addr3;

  logic [7:0] mem [2**ADDR_W];

  // Next-state decode, handshake/status outputs and byte-lane selection
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    wr_en        = 1'b0;
    wr_byte_addr = wr_addr + ADDR_W'(byte_idx);
    wr_byte      = word_reg[31:24];
    case (byte_idx)
      2'd0:    wr_byte = word_reg[31:24];
      2'd1:    wr_byte = word_reg[23:16];
      2'd2:    wr_byte = word_reg[15:8];
      default: wr_byte = word_reg[7:0];
    endcase
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          state_next = (load_len == 7'd0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        wr_en = 1'b1;
        if (byte_idx == 2'd3) begin
          state_next = (remaining == 7'd1) ? DONE : ACCEPT;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus load bookkeeping (target address, words left, byte lane)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_addr   <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word_reg  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (load_start) begin
            wr_addr   <= load_base;
            remaining <= load_len;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            word_reg <= in_word;
            byte_idx <= 2'd0;
          end
        end
        WRITE: begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_addr   <= wr_addr + ADDR_W'(4);
            remaining <= remaining - 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte memory write port; reset suppresses the write so an aborted load stops cleanly
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_byte_addr] <= wr_byte;
    end
  end

  // Fetch addresses for the three following bytes, wrapping at the top of memory
  always_comb begin
    rd_addr1 = rd_addr + ADDR_W'(1);
    rd_addr2 = rd_addr + ADDR_W'(2);
    rd_addr3 = rd_addr + ADDR_W'(3);
  end

  // Registered fetch word; sees pre-write contents when colliding with a write
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= {mem[rd_addr], mem[rd_addr1], mem[rd_addr2], mem[rd_addr3]};
    end
  end

endmodule
